mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data load-store) arbiter in front of one shared
// single-access memory. Data has priority, with a starvation bound for fetches.
module mem_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 InstrReq,
    input  logic [WORD_SIZE-1:0] InstrAddr,
    output logic [WORD_SIZE-1:0] InstrData,
    output logic                 InstrValid,
    input  logic                 DataRead,
    input  logic                 DataWrite,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataWData,
    output logic [WORD_SIZE-1:0] DataRData,
    output logic                 DataDone,
    output logic [WORD_SIZE-1:0] MemAddr,
    output logic [WORD_SIZE-1:0] MemWData,
    output logic                 MemRead,
    output logic                 MemWrite,
    input  logic [WORD_SIZE-1:0] MemRData,
    output logic                 Busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [2:0] WAIT_LOAD  = 3'(MEM_LATENCY - 1);

    logic [1:0] state;
    logic [3:0] starve_cnt;
    logic [2:0] wait_cnt;
    logic       owner_instr;
    logic       is_write;

    logic data_req;
    logic instr_wins;
    logic grant_write;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        data_req    = DataRead | DataWrite;
        instr_wins  = InstrReq && (!data_req || starve_cnt == STARVE_MAX);
        grant_write = !instr_wins && DataWrite;
    end

    // Outputs are registered: the strobes and pulses are set on the edge that
    // enters the state in which they must be visible.
    // NOTE: sequential state uses non-blocking assignments only, so all registers
    // see pre-edge values regardless of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= ST_IDLE;
            starve_cnt  <= '0;
            wait_cnt    <= '0;
            owner_instr <= 1'b0;
            is_write    <= 1'b0;
            InstrData   <= '0;
            InstrValid  <= 1'b0;
            DataRData   <= '0;
            DataDone    <= 1'b0;
            MemAddr     <= '0;
            MemWData    <= '0;
            MemRead     <= 1'b0;
            MemWrite    <= 1'b0;
            Busy        <= 1'b0;
        end else begin
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            InstrValid <= 1'b0;
            DataDone   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (InstrReq || data_req) begin
                        state       <= ST_ACCESS;
                        Busy        <= 1'b1;
                        owner_instr <= instr_wins;
                        is_write    <= grant_write;
                        MemAddr     <= instr_wins ? InstrAddr : DataAddr;
                        MemRead     <= !grant_write;
                        MemWrite    <= grant_write;
                        if (grant_write) begin
                            MemWData <= DataWData;
                        end
                        if (instr_wins) begin
                            starve_cnt <= '0;
                        end else if (InstrReq && starve_cnt != STARVE_MAX) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (is_write) begin
                        state    <= ST_DONE;
                        DataDone <= 1'b1;
                    end else begin
                        state    <= ST_WAIT;
                        wait_cnt <= WAIT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state <= ST_DONE;
                        if (owner_instr) begin
                            InstrValid <= 1'b1;
                            InstrData  <= MemRData;
                        end else begin
                            DataDone  <= 1'b1;
                            DataRData <= MemRData;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// corner sequences, and a randomized run against a transaction-level model.
module tb_mem_arbiter;

    localparam int LAT = 1;
    localparam int SL  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ireq, ivalid, dread, dwrite, ddone, mread, mwrite, busy;
    logic [15:0] iaddr, idata, daddr, dwdata, drdata, maddr, mwdata, mrdata;

    logic        dread3, ddone3, mread3, mwrite3, busy3, ivalid3;
    logic [15:0] daddr3, drdata3, maddr3, mwdata3, mrdata3, idata3;

    mem_arbiter #(.WORD_SIZE(16), .MEM_LATENCY(LAT), .STARVE_LIMIT(SL)) dut (
        .Clock(clk), .Reset(rst),
        .InstrReq(ireq), .InstrAddr(iaddr), .InstrData(idata), .InstrValid(ivalid),
        .DataRead(dread), .DataWrite(dwrite), .DataAddr(daddr), .DataWData(dwdata),
        .DataRData(drdata), .DataDone(ddone),
        .MemAddr(maddr), .MemWData(mwdata), .MemRead(mread), .MemWrite(mwrite),
        .MemRData(mrdata), .Busy(busy)
    );

    mem_arbiter #(.WORD_SIZE(16), .MEM_LATENCY(3), .STARVE_LIMIT(SL)) dut3 (
        .Clock(clk), .Reset(rst),
        .InstrReq(1'b0), .InstrAddr(16'h0000), .InstrData(idata3), .InstrValid(ivalid3),
        .DataRead(dread3), .DataWrite(1'b0), .DataAddr(daddr3), .DataWData(16'h0000),
        .DataRData(drdata3), .DataDone(ddone3),
        .MemAddr(maddr3), .MemWData(mwdata3), .MemRead(mread3), .MemWrite(mwrite3),
        .MemRData(mrdata3), .Busy(busy3)
    );

    // Memory responders: read data appears LAT cycles after the MemRead cycle,
    // and random garbage at every other time so mistimed captures show up.
    logic [15:0] mem  [256];
    logic [15:0] mem3 [256];
    logic [15:0] pipe1;
    logic [15:0] pipe3 [3];

    always @(posedge clk) begin
        if (mwrite) mem[maddr[7:0]] <= mwdata;
        pipe1 <= mread ? mem[maddr[7:0]] : 16'($urandom);
        pipe3[0] <= mread3 ? mem3[maddr3[7:0]] : 16'($urandom);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign mrdata  = pipe1;
    assign mrdata3 = pipe3[2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ireq = 1'b0; dread = 1'b0; dwrite = 1'b0; dread3 = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        ir, dr, dw;
        logic [15:0] ia, da, wd;
        logic        exp_instr;
        logic        exp_write;
        int          exp_cyc;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    // Random-phase model state
    logic        active, t_instr, t_write, done_now, iw, dreq;
    logic [15:0] t_addr, t_wdata, t_rdata, m_idata, m_drdata;
    logic [15:0] ref_mem [256];
    int          g_c, d_c, starve;

    initial begin
        int got, dcyc, icyc, iacc, pulses, r;
        logic saw_instr, both;
        logic [15:0] gdata, ival, dval;
        logic [1:0] order [6];

        rst = 1'b1; ireq = 0; dread = 0; dwrite = 0; dread3 = 0;
        iaddr = 0; daddr = 0; dwdata = 0; daddr3 = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 16'(i * 16'h0101);
            mem3[i] = 16'(i * 16'h0303);
        end
        mem[16'h10]  = 16'h1234;
        mem[16'h20]  = 16'h5678;
        mem3[16'h20] = 16'h9ABC;

        vecs[0] = '{1, 0, 0, 16'h0010, 16'h0000, 16'h0000, 1, 0, 3, 16'h1234};
        vecs[1] = '{0, 1, 0, 16'h0000, 16'h0020, 16'h0000, 0, 0, 3, 16'h5678};
        vecs[2] = '{0, 0, 1, 16'h0000, 16'h0042, 16'hBEEF, 0, 1, 2, 16'h0000};
        vecs[3] = '{1, 1, 0, 16'h0010, 16'h0020, 16'h0000, 0, 0, 3, 16'h5678};
        vecs[4] = '{0, 1, 1, 16'h0000, 16'h0030, 16'hCAFE, 0, 1, 2, 16'h0000};
        vecs[5] = '{1, 0, 1, 16'h0010, 16'h0050, 16'h7777, 0, 1, 2, 16'h0000};

        tick(); tick();
        do_reset();
        check("reset_busy", busy, 0);
        check("reset_strobes", {mread, mwrite, ivalid, ddone}, 0);
        check("reset_buses", {maddr, mwdata}, 0);
        check("reset_rdata", {idata, drdata}, 0);

        // Directed vector table: each applied at cycle 0 straight out of reset.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            ireq = vecs[v].ir; dread = vecs[v].dr; dwrite = vecs[v].dw;
            iaddr = vecs[v].ia; daddr = vecs[v].da; dwdata = vecs[v].wd;
            got = -1; saw_instr = 0; both = 0; gdata = 0;
            for (int k = 1; k <= 8 && got < 0; k++) begin
                tick();
                if (k == 1) begin
                    check($sformatf("v%0d_maddr", v), maddr, vecs[v].exp_instr ? vecs[v].ia : vecs[v].da);
                    check($sformatf("v%0d_mread", v), mread, !vecs[v].exp_write);
                    check($sformatf("v%0d_mwrite", v), mwrite, vecs[v].exp_write);
                    if (vecs[v].exp_write) check($sformatf("v%0d_mwdata", v), mwdata, vecs[v].wd);
                end
                if (ivalid || ddone) begin
                    got = k; saw_instr = ivalid; both = ivalid && ddone;
                    gdata = ivalid ? idata : drdata;
                end
            end
            check($sformatf("v%0d_cycle", v), got, vecs[v].exp_cyc);
            check($sformatf("v%0d_owner", v), {both, saw_instr}, {1'b0, vecs[v].exp_instr});
            if (!vecs[v].exp_write) check($sformatf("v%0d_data", v), gdata, vecs[v].exp_data);
            else check($sformatf("v%0d_memword", v), mem[vecs[v].da[7:0]], vecs[v].wd);
            ireq = 0; dread = 0; dwrite = 0;
        end

        // Both ports at once: data load first, then the fetch.
        do_reset();
        ireq = 1; iaddr = 16'h0010; dread = 1; daddr = 16'h0020;
        dcyc = -1; icyc = -1; iacc = -1; ival = 0; dval = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (ddone) begin dcyc = k; dval = drdata; dread = 0; end
            if (mread && maddr == 16'h0010 && iacc < 0) iacc = k;
            if (ivalid) begin icyc = k; ival = idata; ireq = 0; end
        end
        check("both_data_done", dcyc, 3);
        check("both_data_val", dval, 16'h5678);
        check("both_instr_access", iacc, 5);
        check("both_instr_valid", icyc, 7);
        check("both_instr_data", ival, 16'h1234);

        // A store leaves DataRData at its last loaded value.
        dwrite = 1; daddr = 16'h0042; dwdata = 16'h1357;
        tick();
        check("wr_strobe", {mread, mwrite}, 2'b01);
        check("wr_bus", {maddr, mwdata}, {16'h0042, 16'h1357});
        tick();
        check("wr_done", ddone, 1);
        check("wr_rdata_hold", drdata, 16'h5678);
        dwrite = 0;
        tick();
        check("wr_done_one_cycle", ddone, 0);
        check("wr_memword", mem[8'h42], 16'h1357);

        // Starvation bound: four data grants, then the fetch, then data again.
        do_reset();
        ireq = 1; iaddr = 16'h0010; dread = 1; daddr = 16'h0020;
        pulses = 0;
        for (int k = 0; k < 60 && pulses < 6; k++) begin
            tick();
            if (ivalid || ddone) begin
                order[pulses] = {ivalid, ddone};
                pulses++;
            end
        end
        check("starve_pulses", pulses, 6);
        for (int p = 0; p < 6; p++)
            check($sformatf("starve_order%0d", p), order[p], (p == 4) ? 2'b10 : 2'b01);
        ireq = 0; dread = 0;

        // Reset during WAIT of a load abandons it silently.
        do_reset();
        dread = 1; daddr = 16'h0020;
        tick();
        tick();
        rst = 1;
        tick();
        rst = 0; dread = 0;
        check("rstw_busy", busy, 0);
        check("rstw_strobes", {mread, mwrite, ivalid, ddone}, 0);
        check("rstw_buses", {maddr, mwdata, idata, drdata}, 0);
        tick();
        tick();
        check("rstw_no_done", ddone, 0);
        dread = 1; daddr = 16'h0010;
        got = -1; dval = 0;
        for (int k = 1; k <= 8 && got < 0; k++) begin
            tick();
            if (ddone) begin got = k; dval = drdata; end
        end
        check("rstw_after_cycle", got, 3);
        check("rstw_after_data", dval, 16'h1234);
        dread = 0;

        // Longer memory latency on the second instance.
        do_reset();
        dread3 = 1; daddr3 = 16'h0020;
        got = -1; iacc = -1; dval = 0;
        for (int k = 1; k <= 10 && got < 0; k++) begin
            tick();
            if (mread3 && iacc < 0) iacc = k;
            if (k == 4) check("lat3_busy_wait", busy3, 1);
            if (ddone3) begin got = k; dval = drdata3; end
        end
        check("lat3_mread", iacc, 1);
        check("lat3_done", got, 5);
        check("lat3_data", dval, 16'h9ABC);
        dread3 = 0;

        // Randomized traffic against a transaction-level model.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            r = int'($urandom);
            mem[i] = 16'(r);
            ref_mem[i] = 16'(r);
        end
        active = 0; starve = 0; m_idata = 0; m_drdata = 0;
        t_instr = 0; t_write = 0; t_addr = 0; t_wdata = 0; t_rdata = 0; g_c = 0; d_c = 0;
        for (int n = 0; n < 3000; n++) begin
            check("rnd_busy", busy, active && n > g_c && n <= d_c);
            check("rnd_mread", mread, active && n == g_c + 1 && !t_write);
            check("rnd_mwrite", mwrite, active && n == g_c + 1 && t_write);
            if (active && n == d_c && t_instr) m_idata = t_rdata;
            if (active && n == d_c && !t_instr && !t_write) m_drdata = t_rdata;
            check("rnd_ivalid", ivalid, active && n == d_c && t_instr);
            check("rnd_ddone", ddone, active && n == d_c && !t_instr);
            check("rnd_idata", idata, m_idata);
            check("rnd_drdata", drdata, m_drdata);
            if (active && n == g_c + 1) begin
                check("rnd_maddr", maddr, t_addr);
                if (t_write) check("rnd_mwdata", mwdata, t_wdata);
            end

            done_now = active && n == d_c;
            if (done_now) begin
                active = 0;
                if (t_instr) ireq = 0;
                else begin dread = 0; dwrite = 0; end
            end

            if (!ireq && $urandom_range(0, 3) == 0) ireq = 1;
            if (!(dread || dwrite) && $urandom_range(0, 2) == 0) begin
                r = int'($urandom_range(0, 2));
                dread = (r != 1); dwrite = (r != 0);
            end
            if ($urandom_range(0, 1) == 0) iaddr = 16'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) daddr = 16'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) dwdata = 16'($urandom);

            if (!active && !done_now && (ireq || dread || dwrite)) begin
                dreq    = dread || dwrite;
                iw      = ireq && (!dreq || starve == SL);
                t_instr = iw;
                t_write = !iw && dwrite;
                t_addr  = iw ? iaddr : daddr;
                t_wdata = dwdata;
                if (t_write) ref_mem[t_addr[7:0]] = t_wdata;
                else t_rdata = ref_mem[t_addr[7:0]];
                if (iw) starve = 0;
                else if (ireq && starve < SL) starve++;
                g_c = n;
                d_c = n + (t_write ? 2 : 2 + LAT);
                active = 1;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
